// File: rtl/cdi_video_timing.sv
// rtl/cdi_video_timing.sv - CD-i raster timing: pixel enable, sync/blank, counters, optional colour bars
// Optional colour-bar generator: define CDI_VIDEO_TIMING_TEST_PATTERN_EN.
module cdi_video_timing #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pal,
    output logic       ce_pix,
    output logic       HBlank,
    output logic       HSync,
    output logic       VBlank,
    output logic       VSync,
    output logic [8:0] hcount,
    output logic [8:0] vcount,
    output logic       new_frame,
    output logic       pal_active,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b
);

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

    localparam logic [8:0] H_ACTIVE     = 9'd384;
    localparam logic [8:0] H_SYNC_START = 9'd400;
    localparam logic [8:0] H_SYNC_END   = 9'd431;
    localparam logic [8:0] H_LAST       = 9'd479;

    localparam logic [8:0] NTSC_ACTIVE   = 9'd240;
    localparam logic [8:0] NTSC_VS_START = 9'd244;
    localparam logic [8:0] NTSC_VS_END   = 9'd246;
    localparam logic [8:0] NTSC_LAST     = 9'd261;

    localparam logic [8:0] PAL_ACTIVE   = 9'd280;
    localparam logic [8:0] PAL_VS_START = 9'd284;
    localparam logic [8:0] PAL_VS_END   = 9'd286;
    localparam logic [8:0] PAL_LAST     = 9'd311;

    logic [3:0] div;
    logic       h_last;
    logic       v_last;
    logic       frame_wrap;
    logic [8:0] h_next;
    logic [8:0] v_next;
    logic [8:0] v_active;
    logic [8:0] v_sync_start;
    logic [8:0] v_sync_end;
    logic       hblank_next;
    logic       hsync_next;
    logic       vblank_next;
    logic       vsync_next;

    // Vertical geometry follows the standard latched for the running frame.
    always_comb begin
        v_active     = NTSC_ACTIVE;
        v_sync_start = NTSC_VS_START;
        v_sync_end   = NTSC_VS_END;
        v_last       = (vcount == NTSC_LAST);
        if (pal_active) begin
            v_active     = PAL_ACTIVE;
            v_sync_start = PAL_VS_START;
            v_sync_end   = PAL_VS_END;
            v_last       = (vcount == PAL_LAST);
        end

        h_last     = (hcount == H_LAST);
        frame_wrap = h_last && v_last;

        h_next = h_last ? 9'd0 : hcount + 9'd1;
        v_next = vcount;
        if (h_last) begin
            v_next = v_last ? 9'd0 : vcount + 9'd1;
        end

        hblank_next = (h_next >= H_ACTIVE);
        hsync_next  = (h_next >= H_SYNC_START) && (h_next <= H_SYNC_END);
        vblank_next = (v_next >= v_active);
        vsync_next  = (v_next >= v_sync_start) && (v_next <= v_sync_end);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div        <= 4'd0;
            ce_pix     <= 1'b0;
            hcount     <= 9'd0;
            vcount     <= 9'd0;
            HBlank     <= 1'b0;
            HSync      <= 1'b0;
            VBlank     <= 1'b0;
            VSync      <= 1'b0;
            new_frame  <= 1'b0;
            pal_active <= 1'b0;
        end else begin
            div       <= (div == DIV_LAST) ? 4'd0 : div + 4'd1;
            ce_pix    <= (div == DIV_LAST);
            new_frame <= ce_pix && frame_wrap;
            if (ce_pix) begin
                hcount <= h_next;
                vcount <= v_next;
                HBlank <= hblank_next;
                HSync  <= hsync_next;
                VBlank <= vblank_next;
                VSync  <= vsync_next;
                if (frame_wrap) begin
                    pal_active <= pal;
                end
            end
        end
    end

`ifdef CDI_VIDEO_TIMING_TEST_PATTERN_EN
    logic [2:0] bar;
    logic [5:0] bar_px;
    logic [2:0] bar_next;
    logic [5:0] bar_px_next;
    logic [2:0] color;
    logic       blank_next;

    // Bar state tracks h_next so the registered colour lines up with hcount.
    always_comb begin
        bar_next    = bar;
        bar_px_next = bar_px;
        if (h_next == 9'd0) begin
            bar_next    = 3'd0;
            bar_px_next = 6'd0;
        end else if (h_next < H_ACTIVE) begin
            if (bar_px == 6'd47) begin
                bar_px_next = 6'd0;
                bar_next    = bar + 3'd1;
            end else begin
                bar_px_next = bar_px + 6'd1;
            end
        end
        color      = ~bar_next;
        blank_next = hblank_next || vblank_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bar    <= 3'd0;
            bar_px <= 6'd0;
            r      <= 8'd0;
            g      <= 8'd0;
            b      <= 8'd0;
        end else if (ce_pix) begin
            bar    <= bar_next;
            bar_px <= bar_px_next;
            r      <= blank_next ? 8'd0 : {8{color[2]}};
            g      <= blank_next ? 8'd0 : {8{color[1]}};
            b      <= blank_next ? 8'd0 : {8{color[0]}};
        end
    end
`else
    assign r = 8'd0;
    assign g = 8'd0;
    assign b = 8'd0;
`endif

endmodule

// File: tb/tb_cdi_video_timing.sv
// tb/tb_cdi_video_timing.sv - directed self-checking bench for cdi_video_timing
module tb_cdi_video_timing;

    localparam int CLK_DIV = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       pal = 1'b0;
    logic       ce_pix, HBlank, HSync, VBlank, VSync, new_frame, pal_active;
    logic [8:0] hcount, vcount;
    logic [7:0] r, g, b;

    cdi_video_timing #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .reset_n(reset_n), .pal(pal),
        .ce_pix(ce_pix), .HBlank(HBlank), .HSync(HSync), .VBlank(VBlank), .VSync(VSync),
        .hcount(hcount), .vcount(vcount), .new_frame(new_frame), .pal_active(pal_active),
        .r(r), .g(g), .b(b)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     failures = 0;
    longint n = 0;
    int     e_ce = 0, e_h = 0, e_v = 0, e_hb = 0, e_hs = 0, e_vb = 0, e_vs = 0;
    int     e_nf = 0, e_pa = 0, e_rgb = 0;
    int     exp_h, exp_v, exp_f;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        n++;
        #1;
    endtask

    // Frame 0 is NTSC (262 lines); pal is raised during it, so later frames are PAL (312).
    task automatic exp_pos(input longint p, output int h, output int v, output int f);
        longint line;
        line = p / 480;
        h = int'(p % 480);
        f = 0;
        if (line >= 262) begin
            line -= 262;
            f = 1;
            if (line >= 312) begin
                line -= 312;
                f = 2;
            end
        end
        v = int'(line);
    endtask

    function automatic logic [23:0] exp_rgb(input longint p, input int h, input int v, input int f);
        logic [23:0] res;
        res = 24'd0;
`ifdef CDI_VIDEO_TIMING_TEST_PATTERN_EN
        begin
            logic [2:0] c;
            int va;
            va = (f == 0) ? 240 : 280;
            c = 3'(7 - h / 48);
            if (p != 0 && h < 384 && v < va)
                res = {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
        end
`endif
        return res;
    endfunction

    task automatic compare_model();
        longint p;
        int     va, vs0;
        logic   step;
        p = (n == 0) ? 0 : (n - 1) / CLK_DIV;
        exp_pos(p, exp_h, exp_v, exp_f);
        step = (n > 1) && ((n - 1) % CLK_DIV == 0);
        va  = (exp_f == 0) ? 240 : 280;
        vs0 = (exp_f == 0) ? 244 : 284;
        if (ce_pix !== (n >= 1 && n % CLK_DIV == 0)) e_ce++;
        if (hcount !== 9'(exp_h)) e_h++;
        if (vcount !== 9'(exp_v)) e_v++;
        if (HBlank !== (exp_h >= 384)) e_hb++;
        if (HSync !== (exp_h >= 400 && exp_h <= 431)) e_hs++;
        if (VBlank !== (exp_v >= va)) e_vb++;
        if (VSync !== (exp_v >= vs0 && exp_v <= vs0 + 2)) e_vs++;
        if (new_frame !== (step && exp_h == 0 && exp_v == 0)) e_nf++;
        if (pal_active !== (exp_f >= 1)) e_pa++;
        if ({r, g, b} !== exp_rgb(p, exp_h, exp_v, exp_f)) e_rgb++;
    endtask

    task automatic check_sweep(input string phase);
        check({phase, "_ce_pix"}, e_ce, 0);
        check({phase, "_hcount"}, e_h, 0);
        check({phase, "_vcount"}, e_v, 0);
        check({phase, "_hblank"}, e_hb, 0);
        check({phase, "_hsync"}, e_hs, 0);
        check({phase, "_vblank"}, e_vb, 0);
        check({phase, "_vsync"}, e_vs, 0);
        check({phase, "_new_frame"}, e_nf, 0);
        check({phase, "_pal_active"}, e_pa, 0);
        check({phase, "_rgb"}, e_rgb, 0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_hcount"}, hcount, 0);
        check({tag, "_vcount"}, vcount, 0);
        check({tag, "_ce_sync_blank"}, {ce_pix, HBlank, HSync, VBlank, VSync}, 0);
        check({tag, "_nf_pal"}, {new_frame, pal_active}, 0);
        check({tag, "_rgb"}, {r, g, b}, 0);
    endtask

    longint nf_n1 = -1, nf_n2 = -1;
    int     nf_count = 0;
    int     vmax[3] = '{0, 0, 0};
    int     vs_lines[3] = '{0, 0, 0};
    int     vs_first[3] = '{-1, -1, -1};
    int     vb_first[3] = '{-1, -1, -1};
    int     hs_clocks = 0;
    int     hb_first = -1;
    logic [23:0] rgb_h0, rgb_h48, rgb_h336, rgb_h384;
    logic [23:0] want_h0, want_h48, want_h336;

    initial begin
        longint n_end;

        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");

        reset_n = 1'b1;
        n = 0;
        tick(); compare_model(); check("div_edge1_ce", ce_pix, 0);
        tick(); compare_model(); check("div_edge2_ce", ce_pix, 1);
        tick(); compare_model(); check("div_edge3_ce", ce_pix, 0);
        check("div_edge3_hcount", hcount, 1);

        // Run to hcount 200 on line 150, then reset asynchronously mid-cycle.
        n_end = longint'(150 * 480 + 200) * CLK_DIV + 1;
        while (n < n_end) begin
            tick();
            compare_model();
        end
        check("pre_reset_hcount", hcount, 200);
        check("pre_reset_vcount", vcount, 150);
        check_sweep("phaseA");
        reset_n = 1'b0;
        #1;
        check_reset_state("async_reset");
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset_hold");

        reset_n = 1'b1;
        n = 0;
        n_end = longint'(576 * 480 + 10) * CLK_DIV + 1;
        while (n < n_end) begin
            tick();
            compare_model();
            if (exp_f == 0 && exp_v == 100 && !pal) pal = 1'b1;
            if (new_frame) begin
                nf_count++;
                if (nf_count == 1) begin
                    nf_n1 = n;
                    check("pal_active_after_wrap", pal_active, 1);
                end else if (nf_count == 2) begin
                    nf_n2 = n;
                end
            end
            if (int'(vcount) > vmax[exp_f]) vmax[exp_f] = int'(vcount);
            if (exp_f == 0 && exp_v == 10) begin
                if (HSync) hs_clocks++;
                if (HBlank && hb_first < 0) hb_first = int'(hcount);
            end
            if (n > 1 && (n - 1) % CLK_DIV == 0) begin
                if (exp_h == 0) begin
                    if (VSync) begin
                        vs_lines[exp_f]++;
                        if (vs_first[exp_f] < 0) vs_first[exp_f] = int'(vcount);
                    end
                    if (VBlank && vb_first[exp_f] < 0) vb_first[exp_f] = int'(vcount);
                end
                if (exp_f == 0 && exp_v == 10) begin
                    if (exp_h == 0)   rgb_h0   = {r, g, b};
                    if (exp_h == 48)  rgb_h48  = {r, g, b};
                    if (exp_h == 336) rgb_h336 = {r, g, b};
                    if (exp_h == 384) rgb_h384 = {r, g, b};
                end
            end
        end

        check_sweep("phaseB");
        check("ntsc_first_new_frame_edge", nf_n1, longint'(125760) * CLK_DIV + 1);
        check("pal_frame_period", nf_n2 - nf_n1, longint'(149760) * CLK_DIV);
        check("new_frame_count", nf_count, 2);
        check("ntsc_last_line", vmax[0], 261);
        check("pal_last_line", vmax[1], 311);
        check("ntsc_vsync_lines", vs_lines[0], 3);
        check("ntsc_vsync_first", vs_first[0], 244);
        check("pal_vsync_lines", vs_lines[1], 3);
        check("pal_vsync_first", vs_first[1], 284);
        check("ntsc_vblank_first", vb_first[0], 240);
        check("pal_vblank_first", vb_first[1], 280);
        check("hsync_clocks_per_line", hs_clocks, 32 * CLK_DIV);
        check("hblank_first_hcount", hb_first, 384);

`ifdef CDI_VIDEO_TIMING_TEST_PATTERN_EN
        want_h0 = 24'hFFFFFF;
        want_h48 = 24'hFFFF00;
        want_h336 = 24'h000000;
`else
        want_h0 = 24'h000000;
        want_h48 = 24'h000000;
        want_h336 = 24'h000000;
`endif
        check("rgb_h0", rgb_h0, want_h0);
        check("rgb_h48", rgb_h48, want_h48);
        check("rgb_h336", rgb_h336, want_h336);
        check("rgb_h384", rgb_h384, 24'h000000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
